rvvi_depacketizer: RTL and testbench

Receive-side counterpart of the RVVI packetizer. Accepts 32-bit Ethernet frame words from the MAC receive stream, checks the header against the programmed MAC addresses, EthType and type tag, then reassembles the frame count and RVVI payload into one wide record. The record is delivered on a valid/ready interface to the host-side checker or ack logic. Frames that are malformed or not addressed to the block are discarded and counted.

---
 rtl/rvvi_depacketizer.sv | 141 ++++++++++++++
 tb/tb_rvvi_depacketizer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rvvi_depacketizer.sv
// RVVI receive depacketizer: header check, frame-count/payload reassembly, record hold.
// Optional sequence check enabled by RVVI_DEPKT_SEQCHECK_EN.
module rvvi_depacketizer #(
  parameter int PAYLOAD_WIDTH     = 128,
  parameter int FRAME_COUNT_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  RxData,
  input  logic                         RxValid,
  input  logic                         RxLast,
  output logic                         RxReady,
  input  logic [47:0]                  ExpSrcMac,
  input  logic [47:0]                  ExpDstMac,
  input  logic [15:0]                  EthType,
  input  logic [15:0]                  TypeTag,
  output logic [PAYLOAD_WIDTH-1:0]     Payload,
  output logic [FRAME_COUNT_WIDTH-1:0] PayloadFrameCount,
  output logic                         PayloadValid,
  input  logic                         PayloadReady,
  output logic [15:0]                  DropCount,
  output logic                         SeqError
);
  localparam int FC   = FRAME_COUNT_WIDTH / 32;
  localparam int PW   = PAYLOAD_WIDTH / 32;
  localparam int MAXW = (FC > PW) ? ((FC > 4) ? FC : 4) : ((PW > 4) ? PW : 4);
  localparam int CW   = $clog2(MAXW);
  localparam logic [CW-1:0] HDR_LAST = CW'(3);
  localparam logic [CW-1:0] FC_LAST  = CW'(FC - 1);
  localparam logic [CW-1:0] PW_LAST  = CW'(PW - 1);

  typedef enum logic [2:0] {
    S_HEADER, S_COUNT, S_PAYLOAD, S_TAIL, S_DRAIN, S_HOLD
  } state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [PAYLOAD_WIDTH-1:0]     pl_q, pl_d;
  logic [FRAME_COUNT_WIDTH-1:0] fc_q, fc_d;
  logic [15:0]                  drop_q, drop_d;
  logic                         xfer, drop;
  logic [31:0]                  hdr_exp;

  // Ready is purely a function of state; held low while reset is asserted.
  assign RxReady           = ~reset & (state_q != S_HOLD);
  assign PayloadValid      = (state_q == S_HOLD);
  assign Payload           = pl_q;
  assign PayloadFrameCount = fc_q;
  assign DropCount         = drop_q;
  assign xfer              = RxValid & RxReady;

  always_comb begin
    hdr_exp = '0;
    case (int'(cnt_q))
      0:       hdr_exp = ExpSrcMac[31:0];
      1:       hdr_exp = {ExpDstMac[15:0], ExpSrcMac[47:32]};
      2:       hdr_exp = ExpDstMac[47:16];
      3:       hdr_exp = {TypeTag, EthType};
      default: hdr_exp = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pl_d    = pl_q;
    fc_d    = fc_q;
    drop    = 1'b0;
    drop_d  = drop_q;
    case (state_q)
      S_HEADER: if (xfer) begin
        if (RxData != hdr_exp) begin
          if (RxLast) drop = 1'b1;
          else        state_d = S_DRAIN;
        end else if (RxLast)      drop = 1'b1;
        else if (cnt_q == HDR_LAST) state_d = S_COUNT;
        else                      cnt_d = cnt_q + 1'b1;
      end
      S_COUNT: if (xfer) begin
        fc_d[32*int'(cnt_q) +: 32] = RxData;
        if (RxLast)                drop = 1'b1;
        else if (cnt_q == FC_LAST) state_d = S_PAYLOAD;
        else                       cnt_d = cnt_q + 1'b1;
      end
      S_PAYLOAD: if (xfer) begin
        pl_d[32*int'(cnt_q) +: 32] = RxData;
        if (cnt_q == PW_LAST) state_d = RxLast ? S_HOLD : S_TAIL;
        else if (RxLast)      drop = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end
      S_TAIL:  if (xfer && RxLast) state_d = S_HOLD;
      S_DRAIN: if (xfer && RxLast) drop = 1'b1;
      S_HOLD:  if (PayloadReady) state_d = S_HEADER;
      default: state_d = S_HEADER;
    endcase
    // Every drop lands back in HEADER with a fresh word counter.
    if (drop) state_d = S_HEADER;
    if (drop || (state_d != state_q)) cnt_d = '0;
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_HEADER;
      cnt_q   <= '0;
      pl_q    <= '0;
      fc_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pl_q    <= pl_d;
      fc_q    <= fc_d;
      drop_q  <= drop_d;
    end
  end

`ifdef RVVI_DEPKT_SEQCHECK_EN
  logic [FRAME_COUNT_WIDTH-1:0] exp_q;
  logic                         exp_vld_q, seq_q;

  // Flag is computed on the HOLD entry edge so it lines up with the valid rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q     <= '0;
      exp_vld_q <= 1'b0;
      seq_q     <= 1'b0;
    end else begin
      seq_q <= (state_q != S_HOLD) && (state_d == S_HOLD) && exp_vld_q && (fc_q != exp_q);
      if ((state_q == S_HOLD) && PayloadReady) begin
        exp_q     <= fc_q + FRAME_COUNT_WIDTH'(1);
        exp_vld_q <= 1'b1;
      end
    end
  end
  assign SeqError = seq_q;
`else
  assign SeqError = 1'b0;
`endif

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// Directed bench for rvvi_depacketizer with a frame-level reference model and scoreboard.
module tb_rvvi_depacketizer;
  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  RxData;
  logic         RxValid, RxLast, RxReady;
  logic [47:0]  ExpSrcMac, ExpDstMac;
  logic [15:0]  EthType, TypeTag;
  logic [127:0] Payload;
  logic [63:0]  PayloadFrameCount;
  logic         PayloadValid, PayloadReady, SeqError;
  logic [15:0]  DropCount;

  rvvi_depacketizer #(.PAYLOAD_WIDTH(128), .FRAME_COUNT_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .RxData(RxData), .RxValid(RxValid), .RxLast(RxLast),
    .RxReady(RxReady), .ExpSrcMac(ExpSrcMac), .ExpDstMac(ExpDstMac), .EthType(EthType),
    .TypeTag(TypeTag), .Payload(Payload), .PayloadFrameCount(PayloadFrameCount),
    .PayloadValid(PayloadValid), .PayloadReady(PayloadReady), .DropCount(DropCount),
    .SeqError(SeqError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] pl;
    logic [63:0]  fc;
    logic         se;
  } rec_t;

  int          tests = 0, fails = 0;
  logic [31:0] frm[$];
  rec_t        expq[$];
  int          m_drops = 0;
  bit          m_have_prev = 0;
  logic [63:0] m_prev = '0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Hand-written header words for the programmed addresses/types below.
  task automatic mk_frame(input logic [63:0] fc, input logic [31:0] base, input int pad);
    frm.delete();
    frm.push_back(32'h0C0D0E0F);
    frm.push_back(32'h55660A0B);
    frm.push_back(32'h11223344);
    frm.push_back(32'h525488B5);
    frm.push_back(fc[31:0]);
    frm.push_back(fc[63:32]);
    for (int k = 0; k < 4; k++) frm.push_back(base + 32'(k));
    for (int k = 0; k < pad; k++) frm.push_back(32'hDEAD0000 + 32'(k));
  endtask

  // Frame-level model: accepted iff long enough and all header words match.
  task automatic model_frame();
    rec_t r;
    bit   ok;
    ok = (frm.size() >= 10) &&
         (frm[0] == ExpSrcMac[31:0]) &&
         (frm[1] == {ExpDstMac[15:0], ExpSrcMac[47:32]}) &&
         (frm[2] == ExpDstMac[47:16]) &&
         (frm[3] == {TypeTag, EthType});
    if (!ok) begin
      m_drops++;
    end else begin
      r.fc = {frm[5], frm[4]};
      r.pl = {frm[9], frm[8], frm[7], frm[6]};
`ifdef RVVI_DEPKT_SEQCHECK_EN
      r.se = m_have_prev && (r.fc != m_prev + 64'd1);
`else
      r.se = 1'b0;
`endif
      m_prev      = r.fc;
      m_have_prev = 1'b1;
      expq.push_back(r);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int t = 0;
    RxData = d; RxValid = 1'b1; RxLast = l;
    while (!RxReady && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!RxReady) chk("rxready_timeout", 0, 1);
    @(negedge clk);
    RxValid = 1'b0; RxLast = 1'b0;
  endtask

  task automatic send_frame();
    model_frame();
    for (int i = 0; i < frm.size(); i++) send_word(frm[i], i == frm.size() - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every non-reset cycle, check ready/valid relation, record contents, SeqError.
  initial begin
    rec_t cur;
    bit   pv_prev = 0;
    cur.pl = '0; cur.fc = '0; cur.se = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rxready_vs_valid", RxReady, !PayloadValid);
        if (PayloadValid && !pv_prev) begin
          if (expq.size() == 0) begin
            chk("unexpected_record", 1, 0);
          end else begin
            cur = expq.pop_front();
            chk("payload", Payload, cur.pl);
            chk("frame_count", PayloadFrameCount, cur.fc);
            chk("seq_error", SeqError, cur.se);
          end
        end else begin
          chk("seq_error_idle", SeqError, 0);
          if (PayloadValid) begin
            chk("payload_stable", Payload, cur.pl);
            chk("frame_count_stable", PayloadFrameCount, cur.fc);
          end
        end
      end
      pv_prev = PayloadValid && !reset;
    end
  end

  initial begin
    reset = 1'b1; RxData = '0; RxValid = 1'b0; RxLast = 1'b0; PayloadReady = 1'b1;
    ExpSrcMac = 48'h0A0B0C0D0E0F; ExpDstMac = 48'h112233445566;
    EthType = 16'h88B5; TypeTag = 16'h5254;
    idle(2);
    chk("rst_rxready", RxReady, 0);
    chk("rst_valid", PayloadValid, 0);
    reset = 1'b0;
    idle(1);
    chk("rst_rxready_after", RxReady, 1);
    chk("rst_drop", DropCount, 0);
    chk("rst_seq", SeqError, 0);
    chk("rst_payload", Payload, 0);
    chk("rst_fc", PayloadFrameCount, 0);

    // Good frame: hand-computed record pins the model.
    mk_frame(64'd5, 32'd1, 0);
    send_frame();
    chk("good_valid", PayloadValid, 1);
    chk("good_payload_lit", Payload, 128'h00000004_00000003_00000002_00000001);
    chk("good_fc_lit", PayloadFrameCount, 64'd5);
    idle(1);
    chk("good_valid_one_cycle", PayloadValid, 0);
    chk("good_drop", DropCount, 0);

    // Bad EtherType.
    mk_frame(64'd99, 32'h100, 0);
    frm[3] = 32'h52540800;
    send_frame();
    chk("badeth_drop_lit", DropCount, 16'd1);
    idle(2);

    // Runt: RxLast on frame-count word 0, then a good frame.
    mk_frame(64'd6, 32'h200, 0);
    while (frm.size() > 5) void'(frm.pop_back());
    send_frame();
    chk("runt_drop_lit", DropCount, 16'd2);
    mk_frame(64'd6, 32'h300, 0);
    send_frame();
    idle(2);
    chk("runt_next_drop", DropCount, m_drops);

    // Backpressure with a second frame pending.
    PayloadReady = 1'b0;
    fork
      begin
        mk_frame(64'd7, 32'h400, 0);
        send_frame();
        mk_frame(64'd8, 32'h500, 0);
        send_frame();
      end
      begin
        int t = 0;
        while (!PayloadValid && t < 100) begin
          @(negedge clk);
          t++;
        end
        chk("bp_valid_seen", PayloadValid, 1);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("bp_rxready_low", RxReady, 0);
          chk("bp_valid_held", PayloadValid, 1);
        end
        PayloadReady = 1'b1;
      end
    join
    idle(3);
    chk("bp_all_delivered", expq.size(), 0);

    // Trailing pad words.
    mk_frame(64'd9, 32'h600, 3);
    send_frame();
    chk("pad_payload_lit", Payload, 128'h00000603_00000602_00000601_00000600);
    idle(2);

    // Reset asserted mid-frame.
    mk_frame(64'd50, 32'h700, 0);
    for (int i = 0; i < 6; i++) send_word(frm[i], 1'b0);
    reset = 1'b1;
    idle(1);
    chk("midrst_rxready", RxReady, 0);
    chk("midrst_drop", DropCount, 0);
    chk("midrst_valid", PayloadValid, 0);
    m_drops = 0; m_have_prev = 0;
    reset = 1'b0;
    idle(1);
    chk("midrst_rxready_after", RxReady, 1);

    // Sequence check: 7, 8, 10.
    mk_frame(64'd7, 32'h800, 0); send_frame();
    mk_frame(64'd8, 32'h900, 0); send_frame();
    mk_frame(64'd10, 32'hA00, 0); send_frame();
`ifdef RVVI_DEPKT_SEQCHECK_EN
    chk("seq_third_lit", SeqError, 1);
`else
    chk("seq_third_lit", SeqError, 0);
`endif
    idle(3);
    chk("end_queue_empty", expq.size(), 0);
    chk("end_drop", DropCount, m_drops);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
